pixel_pair_feeder: RTL
======================

Name: pixel_pair_feeder

Overview:
- Upstream stage of ImageProcessor.
- Accepts two independent pixel streams, image A and image B, each over a valid/ready handshake, and buffers each in a small FIFO.
- Pairs the buffered pixels in order and presents registered pixelA/pixelB plus a frame-constant opcode to the processor.
- Counts one frame of FRAME_PIXELS pairs, pulses frame_done, then returns to idle.

Parameters:
- FIFO_DEPTH, 4: entries per channel FIFO; power of two, >= 2.
- FRAME_PIXELS, 16: pixel pairs per frame; >= 1.
- CNT_W, $clog2(FRAME_PIXELS+1): width of the frame counters (derived).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin frame; sampled only in IDLE
- cfg_opcode  in  opcodes_t  operation for the frame, latched on an accepted start
- a_pixel  in  pixel_t  channel A data
- a_valid  in  1  channel A data valid
- a_ready  out  1  channel A can accept
- b_pixel  in  pixel_t  channel B data
- b_valid  in  1  channel B data valid
- b_ready  out  1  channel B can accept
- pixelA  out  pixel_t  paired A pixel to processor
- pixelB  out  pixel_t  paired B pixel to processor
- opcode  out  opcodes_t  latched frame opcode
- out_valid  out  1  pixelA/pixelB hold a valid pair
- out_ready  in  1  consumer takes the pair; tie high for an always-ready consumer
- busy  out  1  high in RUN and DONE
- frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE; FIFOs empty; all counters 0; pixelA=pixelB=0; opcode=0; out_valid=0; a_ready=b_ready=0; busy=0; frame_done=0.
- A reset asserted mid-frame discards all buffered data immediately. No partial output survives.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start=1. Latches cfg_opcode into opcode and clears the accept and issue counters.
  - RUN -> DONE on the output handshake (out_valid & out_ready) that completes pair FRAME_PIXELS.
  - DONE -> IDLE unconditionally after one cycle. frame_done=1 only in DONE.
  - start outside IDLE is ignored. opcode is stable from RUN entry until the next accepted start.
- Input acceptance:
  - a_ready = (state==RUN) & !fifoA_full & (a_accepted < FRAME_PIXELS); b_ready uses the same rule on channel B.
  - Ready is computed from the registered full flag only. A full FIFO does not accept in the same cycle as a pop (no lookahead).
  - A push occurs on valid & ready. The channels are independent, so one may run ahead of the other up to FIFO_DEPTH entries.
- Pairing and output:
  - pop_both when both FIFOs are non-empty and the output slot is free (!out_valid | out_ready).
  - On pop_both: pixelA/pixelB load the FIFO heads, out_valid is set, and issued increments.
  - On out_ready with no pop, out_valid clears.
  - pixelA/pixelB hold their value while out_valid & !out_ready.
- Latency: no FIFO bypass. A pixel accepted at clock edge t, with its partner already buffered and the slot free, is popped at edge t+1, so out_valid rises after edge t+1.
- Throughput: one pair per cycle sustained when both inputs are valid every cycle and out_ready=1.
- Boundaries:
  - Either FIFO empty: no pop; out_valid drops after the pending pair is consumed.
  - FIFO full: that channel's ready is low.
  - Pointers wrap modulo FIFO_DEPTH; full/empty are distinguished by an extra pointer bit.
  - The accept counters saturate the frame, so both FIFOs are empty on entry to DONE.
  - A push and a pop on the same FIFO in the same cycle leave the occupancy unchanged.
- Arithmetic: all counters are CNT_W unsigned and never exceed FRAME_PIXELS.

Decomposition:
- ImageProcessingPkg holds:
  - pixel_t (8-bit grayscale);
  - opcodes_t;
  - a feeder_state_t enum {IDLE, RUN, DONE}.
- Sub-module pixel_fifo, instantiated twice:
  - parameterized by FIFO_DEPTH and pixel_t;
  - ports push, pop, din, dout, full, empty;
  - asynchronous active-high reset.

Test Plan:
- Reset mid-frame: start, push 3 pixels per channel, assert rst -> all outputs at reset values immediately; after release, a_ready=0 until the next start.
- Basic frame: FRAME_PIXELS=4, start with cfg_opcode=OP_ADD, A={10,20,30,40}, B={1,2,3,4} every cycle, out_ready=1 -> pairs (10,1),(20,2),(30,3),(40,4) on consecutive cycles; opcode=OP_ADD; frame_done pulses once exactly 1 cycle after the 4th handshake; then IDLE.
- Skewed channels: push all 4 A pixels while B is idle -> a_ready drops once 4 are accepted (FIFO_DEPTH=4), out_valid=0; then push B -> pairs emitted in order with no loss.
- Backpressure: out_ready=0 for 5 cycles mid-frame -> pixelA/pixelB held, FIFOs fill, a_ready=b_ready=0; release -> remaining pairs resume in order.
- Start during RUN: pulse start with cfg_opcode=OP_SUB mid-frame -> opcode stays OP_ADD; frame length is unchanged.
- Over-supply: drive 6 valid pixels per channel with FRAME_PIXELS=4 -> exactly 4 accepted per channel; ready is low for the remainder and in IDLE.

Source files
------------

// File: rtl/pixel_pair_feeder_pkg.sv
// pixel_pair_feeder_pkg: shared pixel, opcode and feeder state types
package pixel_pair_feeder_pkg;

    typedef logic [7:0] pixel_t;

    typedef enum logic [1:0] {
        OP_NONE    = 2'd0,
        OP_ADD     = 2'd1,
        OP_SUB     = 2'd2,
        OP_ABSDIFF = 2'd3
    } opcodes_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/pixel_pair_feeder_fifo.sv
// pixel_fifo: small synchronous FIFO, extra pointer bit separates full from empty
module pixel_fifo
    import pixel_pair_feeder_pkg::*;
#(
    parameter int  FIFO_DEPTH = 4,
    parameter type data_t     = pixel_t
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  logic  pop,
    input  data_t din,
    output data_t dout,
    output logic  full,
    output logic  empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    data_t       mem [FIFO_DEPTH];
    logic        do_push;
    logic        do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = wr_ptr == rd_ptr;
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // storage is not reset; the pointers alone define what is valid
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/pixel_pair_feeder.sv
// pixel_pair_feeder: buffers two pixel streams, pairs them in order and
// presents one frame of FRAME_PIXELS pairs with a frame-constant opcode
module pixel_pair_feeder
    import pixel_pair_feeder_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int FRAME_PIXELS = 16,
    parameter int CNT_W        = $clog2(FRAME_PIXELS + 1)
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     start,
    input  opcodes_t cfg_opcode,
    input  pixel_t   a_pixel,
    input  logic     a_valid,
    output logic     a_ready,
    input  pixel_t   b_pixel,
    input  logic     b_valid,
    output logic     b_ready,
    output pixel_t   pixelA,
    output pixel_t   pixelB,
    output opcodes_t opcode,
    output logic     out_valid,
    input  logic     out_ready,
    output logic     busy,
    output logic     frame_done
);

    localparam logic [CNT_W-1:0] FRAME = CNT_W'(FRAME_PIXELS);

    feeder_state_t    state;
    feeder_state_t    state_nxt;
    logic [CNT_W-1:0] a_cnt;
    logic [CNT_W-1:0] b_cnt;
    logic [CNT_W-1:0] issued;
    logic             a_full;
    logic             a_empty;
    logic             b_full;
    logic             b_empty;
    pixel_t           a_head;
    pixel_t           b_head;
    logic             a_push;
    logic             b_push;
    logic             pop_both;
    logic             take;
    logic             last;

    pixel_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .data_t(pixel_t)) u_fifo_a (
        .clk   (clk),
        .rst   (rst),
        .push  (a_push),
        .pop   (pop_both),
        .din   (a_pixel),
        .dout  (a_head),
        .full  (a_full),
        .empty (a_empty)
    );

    pixel_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .data_t(pixel_t)) u_fifo_b (
        .clk   (clk),
        .rst   (rst),
        .push  (b_push),
        .pop   (pop_both),
        .din   (b_pixel),
        .dout  (b_head),
        .full  (b_full),
        .empty (b_empty)
    );

    // accept counters cap each channel at one frame, so the FIFOs drain empty by DONE
    always_comb begin
        a_ready    = (state == RUN) && !a_full && (a_cnt < FRAME);
        b_ready    = (state == RUN) && !b_full && (b_cnt < FRAME);
        a_push     = a_valid && a_ready;
        b_push     = b_valid && b_ready;
        pop_both   = (state == RUN) && !a_empty && !b_empty && (!out_valid || out_ready);
        last       = out_valid && out_ready && (issued == FRAME);
        take       = (state == IDLE) && start;
        busy       = state != IDLE;
        frame_done = state == DONE;
        state_nxt  = state == IDLE ? (start ? RUN : IDLE) :
                     state == RUN  ? (last ? DONE : RUN) : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_cnt     <= '0;
            b_cnt     <= '0;
            issued    <= '0;
            opcode    <= OP_NONE;
            pixelA    <= '0;
            pixelB    <= '0;
            out_valid <= 1'b0;
        end else begin
            if (take) begin
                opcode <= cfg_opcode;
                a_cnt  <= '0;
                b_cnt  <= '0;
                issued <= '0;
            end else begin
                if (a_push) a_cnt <= a_cnt + 1'b1;
                if (b_push) b_cnt <= b_cnt + 1'b1;
                if (pop_both) issued <= issued + 1'b1;
            end
            if (pop_both) begin
                pixelA    <= a_head;
                pixelB    <= b_head;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
